// File: rtl/netwalk_program_scheduler_if.sv
// Bundle between flow-table programming requesters, the scheduler and the table write port.
// Handshake: req[i] is a level a source holds until it sees grant[i] pulse; done[i]/done_err report the end of that write.
interface netwalk_program_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 356
);
    logic                        glbl_program_en;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ*DATA_W-1:0]   req_mask;
    logic                        tbl_busy;
    logic                        tbl_ack;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        done_err;
    logic                        of_dpl_program_enable;
    logic [DATA_W-1:0]           of_dpl_program_data;
    logic [DATA_W-1:0]           of_dpl_program_mask;
    logic                        sched_busy;
    logic [1:0]                  dbg_state;

    modport master (
        output glbl_program_en, req, req_data, req_mask, tbl_busy, tbl_ack,
        input  grant, done, done_err, of_dpl_program_enable, of_dpl_program_data,
               of_dpl_program_mask, sched_busy, dbg_state
    );

    modport slave (
        input  glbl_program_en, req, req_data, req_mask, tbl_busy, tbl_ack,
        output grant, done, done_err, of_dpl_program_enable, of_dpl_program_data,
               of_dpl_program_mask, sched_busy, dbg_state
    );
endinterface

// File: rtl/netwalk_program_scheduler.sv
// Round-robin arbiter that serialises flow-table writes: grant, fixed enable hold,
// then wait for the table ack with a timeout abort. One write in flight at a time.
module netwalk_program_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 356,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input logic                        clk,
    input logic                        reset,
    netwalk_program_scheduler_if.slave bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PROG     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                done_err_q, done_err_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mask_q, mask_d;

    logic [2*NUM_REQ-1:0] req_rot_wide;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       offset, win_sum, next_sum;
    logic [IDX_W-1:0]     win_idx, next_ptr;
    logic [DATA_W-1:0]    win_data, win_mask;

    // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is then the winner's distance.
    always_comb begin
        req_rot_wide = {bus.req, bus.req} >> rr_ptr_q;
        req_rot      = req_rot_wide[NUM_REQ-1:0];
        offset       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) offset = (IDX_W+1)'(k);
        end
        win_sum = {1'b0, rr_ptr_q} + offset;
        if (win_sum >= (IDX_W+1)'(NUM_REQ)) win_sum = win_sum - (IDX_W+1)'(NUM_REQ);
        win_idx  = win_sum[IDX_W-1:0];
        next_sum = win_sum + (IDX_W+1)'(1);
        if (next_sum >= (IDX_W+1)'(NUM_REQ)) next_sum = '0;
        next_ptr = next_sum[IDX_W-1:0];
        win_data = '0;
        win_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = bus.req_data[i*DATA_W +: DATA_W];
                win_mask = bus.req_mask[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        grant_d    = '0;
        done_d     = '0;
        done_err_d = done_err_q;
        enable_d   = enable_q;
        data_d     = data_q;
        mask_d     = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.glbl_program_en && !bus.tbl_busy && (|bus.req)) begin
                    state_d    = ST_PROG;
                    grant_d    = NUM_REQ'(1) << win_idx;
                    data_d     = win_data;
                    mask_d     = win_mask;
                    enable_d   = 1'b1;
                    hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                    rr_ptr_d   = next_ptr;
                    win_d      = win_idx;
                end
            end
            ST_PROG: begin
                if (hold_cnt_q == '0) begin
                    enable_d  = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                // An ack arriving on the timeout edge wins, so the write is reported good.
                if (bus.tbl_ack) begin
                    done_d     = NUM_REQ'(1) << win_q;
                    done_err_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    done_d     = NUM_REQ'(1) << win_q;
                    done_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            done_err_q <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.grant                 = grant_q;
    assign bus.done                  = done_q;
    assign bus.done_err              = done_err_q;
    assign bus.of_dpl_program_enable = enable_q;
    assign bus.of_dpl_program_data   = data_q;
    assign bus.of_dpl_program_mask   = mask_q;
    assign bus.sched_busy            = busy_q;
    assign bus.dbg_state             = state_q;
endmodule

// File: tb/tb_netwalk_program_scheduler.sv
// Randomised bench for netwalk_program_scheduler with a write-lifetime reference model
// and a per-cycle comparison of every output.
module tb_netwalk_program_scheduler;
    localparam int NR   = 3;
    localparam int DW   = 356;
    localparam int HOLD = 2;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    netwalk_program_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus_if ();

    netwalk_program_scheduler #(
        .NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a write is described by its age in cycles since the grant.
    bit            m_fly;
    int            m_age;
    int            m_win;
    int            m_ptr;
    logic [NR-1:0] e_grant, e_done;
    logic          e_err, e_en, e_busy;
    logic [DW-1:0] e_data, e_mask;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) w = (w << 32) | DW'($urandom());
        return w;
    endfunction

    task automatic model_reset();
        m_fly = 1'b0; m_age = 0; m_win = 0; m_ptr = 0;
        e_grant = '0; e_done = '0; e_err = 1'b0; e_en = 1'b0; e_busy = 1'b0;
        e_data = '0; e_mask = '0;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        e_grant = '0;
        e_done  = '0;
        if (!m_fly) begin
            if (bus_if.glbl_program_en && !bus_if.tbl_busy && (bus_if.req != '0)) begin
                int w;
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    if (w < 0 && bus_if.req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                end
                m_win = w;
                m_ptr = (w + 1) % NR;
                m_fly = 1'b1;
                m_age = 0;
                e_grant[w] = 1'b1;
                e_en   = 1'b1;
                e_data = bus_if.req_data[w*DW +: DW];
                e_mask = bus_if.req_mask[w*DW +: DW];
            end
        end else if (m_age < HOLD) begin
            m_age++;
            e_en = (m_age < HOLD);
        end else if (bus_if.tbl_ack) begin
            e_done[m_win] = 1'b1;
            e_err = 1'b0;
            m_fly = 1'b0;
        end else if (m_age - HOLD == TMO - 1) begin
            e_done[m_win] = 1'b1;
            e_err = 1'b1;
            m_fly = 1'b0;
        end else begin
            m_age++;
        end
        e_busy = m_fly;
    endtask

    task automatic check_outputs();
        check("grant",    DW'(bus_if.grant),    DW'(e_grant));
        check("done",     DW'(bus_if.done),     DW'(e_done));
        check("done_err", DW'(bus_if.done_err), DW'(e_err));
        check("enable",   DW'(bus_if.of_dpl_program_enable), DW'(e_en));
        check("data",     bus_if.of_dpl_program_data, e_data);
        check("mask",     bus_if.of_dpl_program_mask, e_mask);
        check("busy",     DW'(bus_if.sched_busy), DW'(e_busy));
    endtask

    task automatic drive(input int ack_pct, input int req_pct, input int blk_pct, input int drop_pct);
        logic [NR-1:0] r;
        r = bus_if.req & ~e_grant;
        for (int i = 0; i < NR; i++) begin
            if (!r[i] && $urandom_range(99) < req_pct) begin
                r[i] = 1'b1;
                bus_if.req_data[i*DW +: DW] = rand_word();
                bus_if.req_mask[i*DW +: DW] = rand_word();
            end else if (r[i] && $urandom_range(99) < drop_pct) begin
                r[i] = 1'b0;
            end
        end
        bus_if.req             = r;
        bus_if.tbl_ack         = ($urandom_range(99) < ack_pct);
        bus_if.glbl_program_en = !($urandom_range(99) < blk_pct);
        bus_if.tbl_busy        = ($urandom_range(99) < blk_pct);
    endtask

    task automatic step(input int ack_pct, input int req_pct, input int blk_pct, input int drop_pct);
        @(negedge clk);
        check_outputs();
        drive(ack_pct, req_pct, blk_pct, drop_pct);
        model_step();
    endtask

    initial begin
        int budget;
        reset = 1'b0;
        bus_if.glbl_program_en = 1'b0;
        bus_if.req      = '0;
        bus_if.req_data = '0;
        bus_if.req_mask = '0;
        bus_if.tbl_busy = 1'b0;
        bus_if.tbl_ack  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        drive(0, 100, 0, 0);
        model_step();

        // Contending requests with frequent acks: round-robin order.
        repeat (60) step(30, 100, 0, 0);
        // No acks: every write times out.
        repeat (40) step(0, 60, 0, 0);
        // Mixed traffic with blockers, drops, PROG-time acks and collisions.
        repeat (1500) step(25, 30, 20, 5);

        // Asynchronous reset while enable is high.
        budget = 0;
        forever begin
            @(negedge clk);
            check_outputs();
            if (e_en || budget >= 100) break;
            budget++;
            drive(20, 60, 0, 0);
            model_step();
        end
        check("rst_wait_enable", DW'(bus_if.of_dpl_program_enable), DW'(1'b1));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        bus_if.req             = '1;
        bus_if.tbl_ack         = 1'b0;
        bus_if.tbl_busy        = 1'b0;
        bus_if.glbl_program_en = 1'b1;
        model_step();
        @(negedge clk);
        check("rst_first_grant", DW'(bus_if.grant), DW'(3'b001));
        check_outputs();
        drive(20, 50, 0, 0);
        model_step();

        repeat (200) step(25, 40, 15, 5);
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
